// File: rtl/mem_access_unit_pkg.sv
// Shared types for the data-RAM access unit: access sizes, FSM states and
// the alignment check used at request acceptance.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    ERR,
    RESP
  } state_e;

  // Reserved size is reported through the same error path as misalignment.
  function automatic logic is_misaligned(size_e size, logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      SZ_WORD: is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Big-endian lane steering: extracts/extends load data and merges sub-word
// store data into a previously read word.
module be_lane_unit
  import mem_pkg::*;
(
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        sgn,
  input  logic [31:0] word,
  input  logic [31:0] data,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  // Offset 0 is the most significant byte, so the shift is (3-off)*8.
  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;

  assign sh = {~off, 3'b000};
  assign b  = word[sh +: 8];
  assign h  = off[1] ? word[15:0] : word[31:16];

  always_comb begin
    case (size)
      SZ_BYTE: ld_data = {{24{sgn & b[7]}}, b};
      SZ_HALF: ld_data = {{16{sgn & h[15]}}, h};
      default: ld_data = word;
    endcase
  end

  always_comb begin
    st_word = word;
    case (size)
      SZ_BYTE: st_word[sh +: 8] = data[7:0];
      SZ_HALF: begin
        if (off[1]) st_word[15:0]  = data[15:0];
        else        st_word[31:16] = data[15:0];
      end
      default: st_word = data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-only big-endian RAM: sub-word loads are
// extracted, sub-word stores use read-modify-write, bad accesses error out.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  size_e                 size_q, size_d;
  logic                  write_q, write_d;
  logic                  signed_q, signed_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] lane_word, ld_data, st_word;

  // In READ the live RAM word is steered; in WRITE the captured copy is merged.
  assign lane_word = (state_q == READ) ? ram_rdata : rd_q;

  be_lane_unit u_lane (
    .off     (addr_q[1:0]),
    .size    (size_q),
    .sgn     (signed_q),
    .word    (lane_word),
    .data    (wdata_q),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign ram_we     = (state_q == WRITE);
  assign ram_wdata  = (state_q == WRITE) ? st_word : '0;
  assign ram_addr   = (state_q != IDLE) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    write_d  = write_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          size_d   = size_e'(req_size);
          write_d  = req_write;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = 1'b0;
          if (is_misaligned(size_e'(req_size), req_addr[1:0])) state_d = ERR;
          else if (req_write && size_e'(req_size) == SZ_WORD)  state_d = WRITE;
          else                                                 state_d = READ;
        end
      end
      READ: begin
        rd_d = ram_rdata;
        if (write_q) begin
          state_d = WRITE;
        end else begin
          rdata_d = ld_data;
          state_d = RESP;
        end
      end
      WRITE: state_d = RESP;
      ERR: begin
        err_d   = 1'b1;
        rdata_d = '0;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= SZ_BYTE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      rd_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule
